// File: rtl/counter_scheduler.sv
// counter_scheduler
//
// Shares one external up/down loadable counter among N_REQ requesters on a
// round-robin basis. A granted requester gets a timed run: the counter is
// loaded with its start value, then counts toward all-ones (up) or zero
// (down). When the terminal value appears on cnt_q, the owner receives a
// one-cycle done pulse.
//
// Ports
//   clk         rising-edge clock
//   clear_n     asynchronous active-low reset
//   req         per-requester request level, held until done or abandoned
//   req_start   packed start values; requester i uses [i*WIDTH +: WIDTH]
//   req_up      per-requester direction (1 = up to all-ones, 0 = down to 0)
//   gnt         one-hot owner of the counter (zero while idle)
//   done        one-cycle pulse on the owner's bit at the end of its run
//   busy        high whenever the scheduler is not idle
//   cnt_load    counter load strobe
//   cnt_enable  counter count enable
//   cnt_up      counter direction
//   cnt_v       counter load value
//   cnt_q       counter current value
module counter_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_start,
  input  logic [N_REQ-1:0]       req_up,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   cnt_load,
  output logic                   cnt_enable,
  output logic                   cnt_up,
  output logic [WIDTH-1:0]       cnt_v,
  input  logic [WIDTH-1:0]       cnt_q
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [IW-1:0]    own, own_nxt;
  logic [IW-1:0]    ptr, ptr_nxt;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand;

  logic [WIDTH-1:0] start_arr [N_REQ];
  logic [WIDTH-1:0] own_start;
  logic [WIDTH-1:0] term;
  logic             own_up;
  logic             own_req;
  logic             at_term;

  // Advance an index by one, wrapping at N_REQ (N_REQ need not be a power of 2).
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    if (int'(x) >= N_REQ - 1) return '0;
    return x + IW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      start_arr[i] = req_start[i*WIDTH +: WIDTH];
    end
  end

  // Owner's run parameters are used live, not latched; the requester keeps
  // them stable for the whole grant.
  assign own_start = start_arr[own];
  assign own_up    = req_up[own];
  assign own_req   = req[own];
  assign term      = {WIDTH{own_up}};
  assign at_term   = (cnt_q == term);

  // Round-robin pick: scan downward in offset so the lowest offset from ptr
  // is the last writer and therefore wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr) + i) % N_REQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    own_nxt    = own;
    ptr_nxt    = ptr;
    gnt        = '0;
    done       = '0;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    cnt_up     = 1'b0;
    cnt_v      = '0;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          own_nxt   = pick_idx;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        gnt[own]   = 1'b1;
        cnt_load   = 1'b1;
        cnt_v      = own_start;
        cnt_up     = own_up;
        // A dropped request kills the enable in the same cycle.
        cnt_enable = own_req;
        if (own_req) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
          ptr_nxt   = wrap_inc(own);
        end
      end
      S_RUN: begin
        gnt[own]   = 1'b1;
        cnt_up     = own_up;
        // Enable falls combinationally on terminal so the counter parks there.
        cnt_enable = own_req && !at_term;
        if (!own_req) begin
          state_nxt = S_IDLE;
          ptr_nxt   = wrap_inc(own);
        end else if (at_term) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        gnt[own]  = 1'b1;
        done[own] = 1'b1;
        ptr_nxt   = wrap_inc(own);
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= S_IDLE;
      own   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      own   <= own_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
module tb_counter_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 8;
  localparam int VW    = 2*N_REQ + 3;

  logic                   clk = 1'b0;
  logic                   clear_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_start;
  logic [N_REQ-1:0]       req_up;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   cnt_load;
  logic                   cnt_enable;
  logic                   cnt_up;
  logic [WIDTH-1:0]       cnt_v;
  logic [WIDTH-1:0]       cnt_q;

  int errors = 0;
  int checks = 0;

  counter_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .clear_n(clear_n), .req(req), .req_start(req_start), .req_up(req_up),
    .gnt(gnt), .done(done), .busy(busy), .cnt_load(cnt_load), .cnt_enable(cnt_enable),
    .cnt_up(cnt_up), .cnt_v(cnt_v), .cnt_q(cnt_q)
  );

  always #5 clk = ~clk;

  // Shared external counter: load has priority over enable; no reset.
  logic [WIDTH-1:0] q_reg = '0;
  always @(posedge clk) begin
    if (cnt_load) q_reg <= cnt_v;
    else if (cnt_enable) q_reg <= cnt_up ? q_reg + 1'b1 : q_reg - 1'b1;
  end
  assign cnt_q = q_reg;

  task automatic set_cfg(input int i, input logic [WIDTH-1:0] s, input logic u);
    req_start[i*WIDTH +: WIDTH] = s;
    req_up[i] = u;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_n = 1'b0;
    req = '0;
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_n = 1'b0; req = '0; req_start = '0; req_up = '0;
    #1;
    checks++;
    if ({gnt, done, busy, cnt_load, cnt_enable, cnt_up, cnt_v} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b done=%b busy=%b load=%b en=%b up=%b v=%h want all 0",
               gnt, done, busy, cnt_load, cnt_enable, cnt_up, cnt_v);
    end
    req = 4'b0001;
    @(negedge clk); #1;
    checks++;
    if ({gnt, busy, cnt_load, cnt_enable} !== '0) begin
      errors++;
      $display("FAIL reset_hold got gnt=%b busy=%b load=%b en=%b want 0", gnt, busy, cnt_load, cnt_enable);
    end
    req = '0;
    clear_n = 1'b1;
  endtask

  // Requester 0, start 5, down: LOAD, six RUN cycles (5..0), DONE.
  task automatic test_single();
    logic [VW-1:0] obs, expv;
    logic [WIDTH-1:0] eq;
    do_reset();
    set_cfg(0, 8'd5, 1'b0);
    @(negedge clk); req = 4'b0001; #1;
    checks++;
    if ({gnt, busy} !== '0) begin
      errors++; $display("FAIL single_idle got gnt=%b busy=%b want 0", gnt, busy);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      obs  = {gnt, done, busy, cnt_load, cnt_enable};
      expv = {4'b0001, (c == 7) ? 4'b0001 : 4'b0000, 1'b1, c == 0, c <= 5};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL single_ctrl c=%0d got %b want %b", c, obs, expv);
      end
      if (c == 0) begin
        checks++;
        if (cnt_v !== 8'd5 || cnt_up !== 1'b0) begin
          errors++; $display("FAIL single_load v=%0d up=%b want 5 0", cnt_v, cnt_up);
        end
      end else begin
        eq = (c <= 6) ? WIDTH'(6 - c) : '0;
        checks++;
        if (cnt_q !== eq) begin
          errors++; $display("FAIL single_q c=%0d got %0d want %0d", c, cnt_q, eq);
        end
      end
    end
    @(negedge clk); req = '0; #1;
    checks++;
    if ({gnt, done, busy} !== '0 || cnt_q !== 8'd0) begin
      errors++; $display("FAIL single_after gnt=%b done=%b busy=%b q=%0d want 0s and q=0", gnt, done, busy, cnt_q);
    end
  endtask

  // Requester 1, start all-ones, up: zero counting steps, no wrap.
  task automatic test_zero_up();
    logic [VW-1:0] obs, expv;
    set_cfg(1, 8'hFF, 1'b1);
    @(negedge clk); req = 4'b0010; #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      obs  = {gnt, done, busy, cnt_load, cnt_enable};
      expv = {4'b0010, (c == 2) ? 4'b0010 : 4'b0000, 1'b1, c == 0, c == 0};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL zero_ctrl c=%0d got %b want %b", c, obs, expv);
      end
    end
    @(negedge clk); req = '0; #1;
    @(negedge clk); #1;
    checks++;
    if (cnt_q !== 8'hFF || busy !== 1'b0) begin
      errors++; $display("FAIL zero_nowrap q=%h busy=%b want ff 0", cnt_q, busy);
    end
  endtask

  // All four request continuously with zero-length runs: 4-cycle rhythm
  // LOAD, RUN, DONE, IDLE with owners 0,1,2,3,0.
  task automatic test_round_robin();
    logic [VW-1:0] obs, expv;
    logic [N_REQ-1:0] oh;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_cfg(i, (i % 2 == 0) ? 8'hFF : 8'h00, i % 2 == 0);
    @(negedge clk); req = '1; #1;
    for (int g = 0; g < 5; g++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk); #1;
        oh   = N_REQ'(1) << (g % N_REQ);
        obs  = {gnt, done, busy, cnt_load, cnt_enable};
        expv = {(j < 3) ? oh : {N_REQ{1'b0}}, (j == 2) ? oh : {N_REQ{1'b0}}, j != 3, j == 0, j == 0};
        checks++;
        if (obs !== expv) begin
          errors++; $display("FAIL rr g=%0d j=%0d got %b want %b", g, j, obs, expv);
        end
      end
    end
    req = '0;
  endtask

  // req=0101 from ptr=0: 0 then 2. Requester 1 rises while 2 is loading and
  // 0 keeps requesting; after 2 the pointer sits at 3, so 0 is found before 1.
  task automatic test_fairness();
    int order [4] = '{0, 2, 0, 1};
    logic [N_REQ-1:0] oh;
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_cfg(i, (i % 2 == 0) ? 8'hFF : 8'h00, i % 2 == 0);
    @(negedge clk); req = 4'b0101; #1;
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (g == 1 && j == 0) req = 4'b0111;
        #1;
        oh = N_REQ'(1) << order[g];
        if (j == 0) begin
          checks++;
          if (gnt !== oh) begin
            errors++; $display("FAIL fair_gnt g=%0d got %b want %b", g, gnt, oh);
          end
        end
        if (j == 2) begin
          checks++;
          if (done !== oh) begin
            errors++; $display("FAIL fair_done g=%0d got %b want %b", g, done, oh);
          end
        end
      end
    end
    req = '0;
  endtask

  // Start 20 up; drop req[0] when cnt_q shows 25.
  task automatic test_abandon();
    logic [VW-1:0] obs, expv;
    do_reset();
    set_cfg(0, 8'd20, 1'b1);
    @(negedge clk); req = 4'b0001; #1;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) req = '0;
      #1;
      obs  = {gnt, done, busy, cnt_load, cnt_enable};
      expv = {4'b0001, 4'b0000, 1'b1, c == 0, c != 6};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL abandon_ctrl c=%0d got %b want %b", c, obs, expv);
      end
      if (c >= 1) begin
        checks++;
        if (cnt_q !== WIDTH'(19 + c)) begin
          errors++; $display("FAIL abandon_q c=%0d got %0d want %0d", c, cnt_q, 19 + c);
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({gnt, done, busy, cnt_enable} !== '0 || cnt_q !== 8'd25) begin
        errors++; $display("FAIL abandon_idle c=%0d gnt=%b done=%b busy=%b en=%b q=%0d want 0s q=25",
                           c, gnt, done, busy, cnt_enable, cnt_q);
      end
    end
  endtask

  // Reset asserted between edges while the counter shows 100.
  task automatic test_reset_midrun();
    logic [VW-1:0] obs, expv;
    do_reset();
    set_cfg(0, 8'd90, 1'b1);
    @(negedge clk); req = 4'b0001; #1;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (cnt_q !== 8'd100 || gnt !== 4'b0001 || cnt_enable !== 1'b1) begin
      errors++; $display("FAIL midrun_pre q=%0d gnt=%b en=%b want 100 0001 1", cnt_q, gnt, cnt_enable);
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if ({gnt, done, busy, cnt_load, cnt_enable, cnt_up, cnt_v} !== '0) begin
      errors++; $display("FAIL midrun_async gnt=%b done=%b busy=%b load=%b en=%b up=%b v=%h want all 0",
                         gnt, done, busy, cnt_load, cnt_enable, cnt_up, cnt_v);
    end
    @(negedge clk); #1;
    checks++;
    if (cnt_q !== 8'd100 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun_hold q=%0d busy=%b want 100 0", cnt_q, busy);
    end
    req = 4'b0100;
    set_cfg(2, 8'hFF, 1'b1);
    clear_n = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      obs  = {gnt, done, busy, cnt_load, cnt_enable};
      expv = {4'b0100, (c == 2) ? 4'b0100 : 4'b0000, 1'b1, c == 0, c == 0};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL midrun_regrant c=%0d got %b want %b", c, obs, expv);
      end
    end
    req = '0;
  endtask

  // Random requesters against a transaction-level model: each grant is a run
  // of k+3 cycles (k = distance from start to terminal), the owner is the first
  // requester at or after the pointer, and the pointer moves past the owner.
  task automatic test_random(input int ncyc);
    logic [N_REQ-1:0] r_req;
    logic [WIDTH-1:0] r_start [N_REQ];
    logic             r_up [N_REQ];
    logic [VW-1:0]    obs, expv;
    logic [N_REQ-1:0] oh;
    logic [WIDTH-1:0] eq;
    bit m_active, just_done, found;
    int m_own, m_k, m_c, m_ptr, jd_own, off, idx, d;
    do_reset();
    r_req = '0; m_active = 0; m_ptr = 0; just_done = 0; m_own = 0; m_k = 0; m_c = 0; jd_own = 0;
    for (int i = 0; i < N_REQ; i++) begin r_start[i] = '0; r_up[i] = 1'b0; end
    for (int t = 0; t < ncyc; t++) begin
      @(negedge clk);
      if (just_done && $urandom_range(1, 0) == 0) r_req[jd_own] = 1'b0;
      just_done = 0;
      for (int i = 0; i < N_REQ; i++) begin
        if (!r_req[i] && $urandom_range(3, 0) == 0) begin
          off = $urandom_range(5, 0);
          r_up[i] = 1'($urandom_range(1, 0));
          r_start[i] = r_up[i] ? WIDTH'((2**WIDTH - 1) - off) : WIDTH'(off);
          r_req[i] = 1'b1;
        end
      end
      req = r_req;
      for (int i = 0; i < N_REQ; i++) set_cfg(i, r_start[i], r_up[i]);
      #1;
      oh = m_active ? (N_REQ'(1) << m_own) : '0;
      expv = {oh, (m_active && m_c == m_k + 2) ? oh : {N_REQ{1'b0}}, m_active,
              m_active && m_c == 0, m_active && m_c <= m_k};
      obs = {gnt, done, busy, cnt_load, cnt_enable};
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL rand_ctrl t=%0d got %b want %b", t, obs, expv);
      end
      if (m_active && m_c >= 1) begin
        d  = (m_c - 1 < m_k) ? m_c - 1 : m_k;
        eq = r_up[m_own] ? r_start[m_own] + WIDTH'(d) : r_start[m_own] - WIDTH'(d);
        checks++;
        if (cnt_q !== eq) begin
          errors++; $display("FAIL rand_q t=%0d got %0d want %0d", t, cnt_q, eq);
        end
      end
      if (m_active && m_c == 0) begin
        checks++;
        if (cnt_v !== r_start[m_own] || cnt_up !== r_up[m_own]) begin
          errors++; $display("FAIL rand_load t=%0d v=%0d up=%b want %0d %b",
                             t, cnt_v, cnt_up, r_start[m_own], r_up[m_own]);
        end
      end
      if (!m_active) begin
        found = 0;
        for (int o = 0; o < N_REQ; o++) begin
          idx = (m_ptr + o) % N_REQ;
          if (!found && r_req[idx]) begin
            found = 1; m_own = idx;
          end
        end
        if (found) begin
          m_active = 1; m_c = 0;
          m_k = r_up[m_own] ? (2**WIDTH - 1) - int'(r_start[m_own]) : int'(r_start[m_own]);
        end
      end else begin
        m_c++;
        if (m_c > m_k + 2) begin
          m_active = 0;
          m_ptr = (m_own + 1) % N_REQ;
          just_done = 1; jd_own = m_own;
        end
      end
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_up();
    test_round_robin();
    test_fairness();
    test_abandon();
    test_reset_midrun();
    test_random(600);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
